// File: rtl/io_pad_bridge.sv
// Bidirectional pad bridge: synchronises the off-chip side, arbitrates pad
// ownership with a turnaround gap, and flags drive contention.
// Optional build macro IO_PAD_BRIDGE_CONTENTION_CNT_EN adds a saturating event counter.
//
// state | meaning
// KEEP  | nobody drives, O_top holds last value (bus keeper)
// FAB   | fabric drives the pad, O_top follows I_top
// TURN  | fabric released, pad undriven for TURNAROUND cycles
// EXT   | off-chip side drives, O_top follows synchronised PAD_I
module io_pad_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int TURNAROUND  = 2,
  parameter int CONT_THRESH = 3,
  parameter int CNT_W       = 8
) (
  input  logic             UserCLK,
  input  logic             RST,
  input  logic             I_top,
  input  logic             T_top,
  output logic             O_top,
  input  logic             PAD_I,
  input  logic             PAD_OE,
  output logic             PAD_O,
  output logic             PAD_T,
  input  logic             clr_contention,
  output logic             contention,
  output logic [CNT_W-1:0] contention_cnt
);

  typedef enum logic [1:0] {
    KEEP = 2'd0,
    FAB  = 2'd1,
    TURN = 2'd2,
    EXT  = 2'd3
  } state_t;

  localparam logic [3:0] TURN_LOAD = 4'(TURNAROUND - 1);
  localparam logic [3:0] THRESH_M1 = 4'(CONT_THRESH - 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] pad_i_sync_q, pad_oe_sync_q;
  logic                   pad_i_s, pad_oe_s;
  logic [3:0]             turn_cnt_q, turn_cnt_d;
  logic [3:0]             run_cnt_q, run_cnt_d;
  logic                   o_top_q, o_top_d;
  logic                   contention_q, contention_d;
  logic                   pad_t;
  logic                   mismatch, cont_event;

  assign pad_i_s  = pad_i_sync_q[SYNC_STAGES-1];
  assign pad_oe_s = pad_oe_sync_q[SYNC_STAGES-1];

  always_ff @(posedge UserCLK) begin
    if (RST) begin
      pad_i_sync_q  <= '0;
      pad_oe_sync_q <= '0;
    end else begin
      pad_i_sync_q  <= {pad_i_sync_q[SYNC_STAGES-2:0], PAD_I};
      pad_oe_sync_q <= {pad_oe_sync_q[SYNC_STAGES-2:0], PAD_OE};
    end
  end

  // State register together with the counters and flags it sequences.
  always_ff @(posedge UserCLK) begin
    if (RST) begin
      state_q      <= KEEP;
      turn_cnt_q   <= '0;
      run_cnt_q    <= '0;
      o_top_q      <= 1'b0;
      contention_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      turn_cnt_q   <= turn_cnt_d;
      run_cnt_q    <= run_cnt_d;
      o_top_q      <= o_top_d;
      contention_q <= contention_d;
    end
  end

  // Fabric request always wins over the off-chip side, including a TURN abort.
  always_comb begin
    state_d = state_q;
    case (state_q)
      KEEP: if (T_top) state_d = FAB;
            else if (pad_oe_s) state_d = EXT;
      FAB:  if (!T_top) state_d = TURN;
      TURN: if (T_top) state_d = FAB;
            else if (turn_cnt_q == 4'd0) state_d = KEEP;
      EXT:  if (T_top) state_d = FAB;
            else if (!pad_oe_s) state_d = KEEP;
      default: state_d = KEEP;
    endcase
  end

  always_comb begin
    pad_t      = 1'b1;
    o_top_d    = o_top_q;
    turn_cnt_d = turn_cnt_q;
    case (state_q)
      FAB: begin
        pad_t   = 1'b0;
        o_top_d = I_top;
        if (!T_top) turn_cnt_d = TURN_LOAD;
      end
      TURN: if (turn_cnt_q != 4'd0) turn_cnt_d = turn_cnt_q - 4'd1;
      EXT:  o_top_d = pad_i_s;
      default: ;
    endcase
  end

  // The run counter restarts after each event so a stuck mismatch repeats every CONT_THRESH cycles.
  always_comb begin
    mismatch     = (state_q == FAB) && pad_oe_s && (pad_i_s != I_top);
    cont_event   = mismatch && (run_cnt_q == THRESH_M1);
    run_cnt_d    = (mismatch && !cont_event) ? run_cnt_q + 4'd1 : 4'd0;
    contention_d = cont_event | (contention_q & ~clr_contention);
  end

  assign PAD_T      = pad_t;
  assign PAD_O      = I_top;
  assign O_top      = o_top_q;
  assign contention = contention_q;

`ifdef IO_PAD_BRIDGE_CONTENTION_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge UserCLK) begin
    if (RST) cnt_q <= '0;
    else if (cont_event && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign contention_cnt = cnt_q;
`else
  assign contention_cnt = '0;
`endif

endmodule

// File: tb/tb_io_pad_bridge.sv
// Directed bench for io_pad_bridge: sequencing, keeper, sync latency,
// contention flag/counter and reset behaviour with default parameters.
module tb_io_pad_bridge;

  localparam logic [1:0] S_KEEP = 2'd0;
  localparam logic [1:0] S_FAB  = 2'd1;
  localparam logic [1:0] S_TURN = 2'd2;
  localparam logic [1:0] S_EXT  = 2'd3;
`ifdef IO_PAD_BRIDGE_CONTENTION_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, i_top, t_top, pad_i, pad_oe, clr;
  logic       o_top, pad_o, pad_t, cont;
  logic [7:0] cont_cnt;
  int         total = 0;
  int         bad   = 0;

  io_pad_bridge dut (
    .UserCLK        (clk),
    .RST            (rst),
    .I_top          (i_top),
    .T_top          (t_top),
    .O_top          (o_top),
    .PAD_I          (pad_i),
    .PAD_OE         (pad_oe),
    .PAD_O          (pad_o),
    .PAD_T          (pad_t),
    .clr_contention (clr),
    .contention     (cont),
    .contention_cnt (cont_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ecnt(input int n);
    return (CNT_ON != 0) ? 32'(n) : 32'd0;
  endfunction

  initial begin
    rst = 1'b1; i_top = 1'b0; t_top = 1'b0; pad_i = 1'b0; pad_oe = 1'b0; clr = 1'b0;
    tick(); tick();
    check("rst_pad_t", 32'(pad_t), 32'd1);
    check("rst_o_top", 32'(o_top), 32'd0);
    check("rst_cont", 32'(cont), 32'd0);
    check("rst_cnt", 32'(cont_cnt), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(S_KEEP));
    rst = 1'b0;
    tick();
    check("keep_pad_t", 32'(pad_t), 32'd1);

    // fabric takes the pad
    t_top = 1'b1; i_top = 1'b1;
    tick();
    check("fab_state", 32'(dut.state_q), 32'(S_FAB));
    check("fab_pad_t", 32'(pad_t), 32'd0);
    check("fab_pad_o", 32'(pad_o), 32'd1);
    check("fab_o_top_lag", 32'(o_top), 32'd0);
    tick();
    check("fab_o_top", 32'(o_top), 32'd1);

    // release: two turnaround cycles, then keeper
    t_top = 1'b0;
    tick();
    check("turn1_state", 32'(dut.state_q), 32'(S_TURN));
    check("turn1_pad_t", 32'(pad_t), 32'd1);
    check("turn1_o_top", 32'(o_top), 32'd1);
    tick();
    check("turn2_state", 32'(dut.state_q), 32'(S_TURN));
    check("turn2_o_top", 32'(o_top), 32'd1);
    tick();
    check("turn_done_state", 32'(dut.state_q), 32'(S_KEEP));
    check("keep_o_top", 32'(o_top), 32'd1);

    // off-chip drive after synchroniser latency
    pad_oe = 1'b1; pad_i = 1'b0;
    tick();
    check("ext_sync1_state", 32'(dut.state_q), 32'(S_KEEP));
    tick();
    check("ext_sync2_state", 32'(dut.state_q), 32'(S_KEEP));
    tick();
    check("ext_state", 32'(dut.state_q), 32'(S_EXT));
    check("ext_pad_t", 32'(pad_t), 32'd1);
    check("ext_o_top_lag", 32'(o_top), 32'd1);
    tick();
    check("ext_o_top", 32'(o_top), 32'd0);
    pad_oe = 1'b0;
    tick(); tick();
    check("ext_hold_state", 32'(dut.state_q), 32'(S_EXT));
    tick();
    check("ext_exit_state", 32'(dut.state_q), 32'(S_KEEP));
    check("ext_exit_o_top", 32'(o_top), 32'd0);

    // persistent contention: mismatch cycles start on the second FAB edge
    t_top = 1'b1; i_top = 1'b1; pad_oe = 1'b1; pad_i = 1'b0;
    tick(); tick();
    check("cont_pre", 32'(cont), 32'd0);
    tick(); tick();
    check("cont_run2", 32'(cont), 32'd0);
    tick();
    check("cont_set", 32'(cont), 32'd1);
    check("cont_cnt1", 32'(cont_cnt), ecnt(1));
    tick(); tick(); tick();
    check("cont_cnt2", 32'(cont_cnt), ecnt(2));
    tick(); tick(); tick();
    check("cont_cnt3", 32'(cont_cnt), ecnt(3));
    i_top = 1'b0;
    tick();
    check("cont_stop_cnt", 32'(cont_cnt), ecnt(3));

    // clear alone, then clear colliding with a new event
    clr = 1'b1;
    tick();
    check("clr_cont", 32'(cont), 32'd0);
    check("clr_cnt_kept", 32'(cont_cnt), ecnt(3));
    clr = 1'b0; i_top = 1'b1;
    tick(); tick();
    check("rerun_cont", 32'(cont), 32'd0);
    clr = 1'b1;
    tick();
    check("set_wins", 32'(cont), 32'd1);
    check("set_wins_cnt", 32'(cont_cnt), ecnt(4));
    clr = 1'b0;

    // reset in the middle of TURN
    t_top = 1'b0; pad_oe = 1'b0;
    tick();
    check("midturn_state", 32'(dut.state_q), 32'(S_TURN));
    rst = 1'b1;
    tick();
    check("midturn_rst_state", 32'(dut.state_q), 32'(S_KEEP));
    check("midturn_rst_pad_t", 32'(pad_t), 32'd1);
    check("midturn_rst_o_top", 32'(o_top), 32'd0);
    check("midturn_rst_cont", 32'(cont), 32'd0);
    check("midturn_rst_cnt", 32'(cont_cnt), 32'd0);
    check("midturn_rst_run", 32'(dut.run_cnt_q), 32'd0);
    check("midturn_rst_turn", 32'(dut.turn_cnt_q), 32'd0);
    check("midturn_rst_sync", 32'({dut.pad_i_sync_q, dut.pad_oe_sync_q}), 32'd0);

    // TURN abort back to FAB, then reset in the middle of FAB
    rst = 1'b0; t_top = 1'b1;
    tick();
    check("abort_fab_state", 32'(dut.state_q), 32'(S_FAB));
    t_top = 1'b0;
    tick();
    check("abort_turn_state", 32'(dut.state_q), 32'(S_TURN));
    t_top = 1'b1;
    tick();
    check("abort_state", 32'(dut.state_q), 32'(S_FAB));
    check("abort_pad_t", 32'(pad_t), 32'd0);
    rst = 1'b1;
    tick();
    check("midfab_rst_pad_t", 32'(pad_t), 32'd1);
    check("midfab_rst_state", 32'(dut.state_q), 32'(S_KEEP));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
